// File: rtl/mux_scan_n_if.sv
// Bundles the select controls, packed channel data and output handshake of mux_scan_n.
// Optional MUX_SCAN_MASK_EN adds the per-channel scan mask.
interface mux_scan_n_if #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 1,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic                    strobe;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH*WIDTH-1:0] data_input;
    logic                    out_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        data_output;
    logic [SEL_W-1:0]        out_chan;
    logic                    sel_err;
    logic                    state_dbg;
    logic [SEL_W-1:0]        cnt_dbg;
`ifdef MUX_SCAN_MASK_EN
    logic [NUM_CH-1:0]       ch_mask;

    modport master (
        output strobe, mode, sel, data_input, out_ready, ch_mask,
        input  out_valid, data_output, out_chan, sel_err, state_dbg, cnt_dbg
    );
    modport slave (
        input  strobe, mode, sel, data_input, out_ready, ch_mask,
        output out_valid, data_output, out_chan, sel_err, state_dbg, cnt_dbg
    );
`else
    modport master (
        output strobe, mode, sel, data_input, out_ready,
        input  out_valid, data_output, out_chan, sel_err, state_dbg, cnt_dbg
    );
    modport slave (
        input  strobe, mode, sel, data_input, out_ready,
        output out_valid, data_output, out_chan, sel_err, state_dbg, cnt_dbg
    );
`endif
endinterface

// File: rtl/mux_scan_n.sv
// Registered N-channel selector with valid/ready output and auto-scan counter.
// Optional MUX_SCAN_MASK_EN: scan skips channels whose ch_mask bit is 0.
module mux_scan_n #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 1,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input logic         clk,
    input logic         rst,
    mux_scan_n_if.slave bus
);
    // Handshake: a sample moves downstream on any edge where out_valid && out_ready;
    // a new sample may be captured on that same edge, and out_valid never drops
    // without a transfer unless strobe flushes the stage.

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] idx;
    logic             idx_ok;
    logic [WIDTH-1:0] idx_data;
    logic [SEL_W-1:0] cnt_adv;
    logic             src_ok;
    logic             cap;

`ifdef MUX_SCAN_MASK_EN
    // First enabled channel at or above start (mod NUM_CH); returns start if none.
    function automatic logic [SEL_W-1:0] first_en(input int start, input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] r;
        logic             found;
        int               p;
        r     = SEL_W'(start % NUM_CH);
        found = 1'b0;
        for (int o = 0; o < NUM_CH; o++) begin
            p = (start + o) % NUM_CH;
            if (!found && m[SEL_W'(p)]) begin
                r     = SEL_W'(p);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [SEL_W-1:0] scan_idx;

    always_comb begin
        scan_idx = first_en(int'(cnt_q), bus.ch_mask);
        idx      = bus.mode ? scan_idx : bus.sel;
        cnt_adv  = first_en(int'(scan_idx) + 1, bus.ch_mask);
        src_ok   = !bus.mode || (|bus.ch_mask);
    end
`else
    always_comb begin
        idx     = bus.mode ? cnt_q : bus.sel;
        cnt_adv = (cnt_q == LAST_CH) ? '0 : cnt_q + SEL_W'(1);
        src_ok  = 1'b1;
    end
`endif

    // Out-of-range indices match no channel and therefore select zero.
    always_comb begin
        idx_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == SEL_W'(k)) idx_data = bus.data_input[k*WIDTH +: WIDTH];
        end
        idx_ok = ({1'b0, idx} < NUM_CH_W);
    end

    assign cap = !bus.strobe && (state_q == EMPTY || bus.out_ready);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (bus.strobe) begin
            state_d = EMPTY;
            data_d  = '0;
            chan_d  = '0;
        end else if (cap && src_ok) begin
            state_d = FULL;
            data_d  = idx_ok ? idx_data : '0;
            chan_d  = idx;
            if (bus.mode) cnt_d = cnt_adv;
            if (!idx_ok)  err_d = 1'b1;
        end else if (state_q == FULL && bus.out_ready) begin
            // Only reachable when the scan mask is empty: deliver and go idle.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid   = (state_q == FULL);
    assign bus.data_output = data_q;
    assign bus.out_chan    = chan_q;
    assign bus.sel_err     = err_q;
    assign bus.state_dbg   = state_q;
    assign bus.cnt_dbg     = cnt_q;
endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N-channel, W-bit data selector. Generalises the 1-of-8 strobed mux.
- Adds a clocked output register with valid/ready handshake and an auto-scan mode. An internal channel counter steps through the inputs.
- Sits between multi-channel sample sources and a single downstream consumer, such as a display/serialiser stage.

Parameters:
- NUM_CH, 8, number of input channels (2..256).
- WIDTH, 1, bits per channel.
- SEL_W, $clog2(NUM_CH), select/counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- strobe  input  1  active-high disable. While 1, the block flushes and forces zero output.
- mode  input  1  0 = manual select (sel), 1 = auto-scan (internal counter).
- sel  input  SEL_W  channel index used in manual mode.
- data_input  input  NUM_CH*WIDTH  packed channels; channel k = data_input[k*WIDTH +: WIDTH].
- out_ready  input  1  downstream accepts data_output this cycle.
- out_valid  output  1  data_output/out_chan hold a valid sample.
- data_output  output  WIDTH  registered selected sample.
- out_chan  output  SEL_W  channel index the current sample came from.
- sel_err  output  1  sticky flag: an out-of-range channel index was captured.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: out_valid=0, data_output=0, out_chan=0, sel_err=0, scan counter=0. Reset overrides all other inputs.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Capture condition: cap = !strobe && (state==EMPTY || out_ready).
- Capture on clk edge when cap:
  - idx = mode ? cnt : sel.
  - data_output <= data_input channel idx.
  - out_chan <= idx.
  - State -> FULL.
- Latency: 1 cycle from input to data_output.
- With out_ready held high and strobe low: one new sample every cycle (full throughput).
- FULL && !out_ready && !strobe: data_output, out_chan and out_valid hold. Inputs are ignored; no capture.
- Transfer occurs when out_valid && out_ready. The same edge may capture a new sample (back-to-back).
- Scan counter:
  - Increments only on a capture edge with mode=1.
  - Wraps from NUM_CH-1 to 0.
  - Holds in manual mode and while strobe=1.
- Mode change: takes effect at the next capture. Entering scan resumes from the held counter value; it does not restart at 0.
- Strobe=1:
  - Next edge: out_valid=0, data_output=0, out_chan=0, state -> EMPTY.
  - A sample pending in FULL is dropped, not delivered.
  - sel_err and the counter are unaffected.
  - First capture is on the first edge after strobe returns to 0.
- Out-of-range index (idx >= NUM_CH, possible only when NUM_CH is not a power of 2):
  - Capture proceeds with data_output=0 and out_chan=idx.
  - sel_err is set to 1 and stays 1 until rst.
- All outputs are driven from registers. No combinational path from inputs to outputs. No latches.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds input port ch_mask [NUM_CH-1:0].
  - In scan mode the counter advances to the next channel whose mask bit is 1, searching upward with wrap. This search finishes within the capture cycle, so throughput stays one sample per cycle.
  - If the current cnt channel is masked at capture time, capture uses the next enabled channel instead.
  - ch_mask all-zero: no capture; state goes EMPTY after any pending transfer; counter holds.
  - Manual mode ignores ch_mask.
- Undefined: no ch_mask port; scan visits every channel in order.

Test Plan:
- Reset and manual mode: NUM_CH=8, WIDTH=4, channel k = k+1. Reset, mode=0, sel=5, out_ready=1 -> after one edge out_valid=1, data_output=6, out_chan=5; sel=0 next cycle -> data_output=1.
- Auto-scan wrap: mode=1, out_ready=1 for 10 cycles -> out_chan sequence 0,1,...,7,0,1; data_output tracks channel value each cycle.
- Backpressure: FULL with out_chan=3, out_ready=0 for 4 cycles while sel changes -> outputs stable at channel 3; counter holds. Then out_ready=1 -> next sample channel 4 in scan mode.
- Strobe flush: FULL, strobe=1 for 2 cycles -> out_valid=0, data_output=0 after the first edge; counter unchanged. Strobe=0 -> capture resumes at the held counter value.
- Out-of-range: NUM_CH=5, mode=0, sel=6 -> data_output=0, out_chan=6, sel_err=1. sel=2 -> valid data, sel_err stays 1 until rst.
- MUX_SCAN_MASK_EN: ch_mask=8'b1010_0101, mode=1 -> out_chan 0,2,5,7,0,...; ch_mask=0 -> out_valid drops after the pending transfer.
